// File: rtl/seq_emitter.sv
// Emits frames of 01,10,11 on num, repeated repeat_cnt+1 times with gap idle
// symbols between frames; abortable, with a one-cycle done pulse on completion.
module seq_emitter #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  output logic [1:0]       num,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYM1 = 3'd1,
    SYM2 = 3'd2,
    SYM3 = 3'd3,
    GAP  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   frames_q, frames_d;
  logic [GAP_W-1:0]   gap_len_q, gap_len_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      frames_q  <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      frames_q  <= frames_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    frames_d  = frames_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SYM1;
          frames_d  = repeat_cnt;
          gap_len_d = gap;
        end
      end
      SYM1: state_d = abort ? IDLE : SYM2;
      SYM2: state_d = abort ? IDLE : SYM3;
      SYM3: begin
        if (abort) begin
          state_d = IDLE;
        end else if (frames_q == '0) begin
          state_d = DONE;
        end else if (gap_len_q == '0) begin
          state_d  = SYM1;
          frames_d = frames_q - 1'b1;
        end else begin
          state_d   = GAP;
          gap_cnt_d = gap_len_q - 1'b1;
          frames_d  = frames_q - 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gap_cnt_q == '0) begin
          state_d = SYM1;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on the state register.
  always_comb begin
    num  = 2'b00;
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      SYM1:    begin num = 2'b01; busy = 1'b1; end
      SYM2:    begin num = 2'b10; busy = 1'b1; end
      SYM3:    begin num = 2'b11; busy = 1'b1; end
      GAP:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_emitter.sv
// Directed cycle-by-cycle vectors for seq_emitter plus long-run length checks.
module tb_seq_emitter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] repeat_cnt;
  logic [1:0] gap;
  logic [1:0] num;
  logic       busy;
  logic       done;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic       rst;
    logic       st;
    logic       ab;
    logic [3:0] rc;
    logic [1:0] g;
    logic [1:0] e_num;
    logic       e_busy;
    logic       e_done;
    string      name;
  } vec_t;

  vec_t vecs[$];

  seq_emitter #(.CNT_W(4), .GAP_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .repeat_cnt (repeat_cnt),
    .gap        (gap),
    .num        (num),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic st, input logic ab,
                     input logic [3:0] rc, input logic [1:0] g,
                     input logic [1:0] en, input logic eb, input logic ed,
                     input string name);
    vec_t v;
    v.rst = rst; v.st = st; v.ab = ab; v.rc = rc; v.g = g;
    v.e_num = en; v.e_busy = eb; v.e_done = ed; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Runs a full transmission and measures busy length, 11-symbol count, done pulses.
  task automatic long_run(input logic [3:0] rc, input logic [1:0] g,
                          input int exp_busy, input string name);
    int nbusy, n11, ndone, cyc;
    nbusy = 0; n11 = 0; ndone = 0; cyc = 0;
    start = 1'b1; repeat_cnt = rc; gap = g; abort = 1'b0; reset = 1'b0;
    tick();
    start = 1'b0;
    while (ndone == 0 && cyc < 300) begin
      if (busy) nbusy++;
      if (num == 2'b11) n11++;
      if (done) ndone++;
      if (ndone == 0) tick();
      cyc++;
    end
    check({name, "_busy_len"}, nbusy, exp_busy);
    check({name, "_frames"}, n11, int'(rc) + 1);
    check({name, "_done_seen"}, ndone, 1);
    tick();
    check({name, "_idle_after"}, {num, busy, done}, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; repeat_cnt = '0; gap = '0;

    // reset
    add(1,0,0,0,0, 2'b00,0,0, "reset0");
    add(1,1,1,5,1, 2'b00,0,0, "reset_overrides");
    add(0,0,0,0,0, 2'b00,0,0, "idle");
    // single frame
    add(0,1,0,0,0, 2'b01,1,0, "t1_s1");
    add(0,0,0,0,0, 2'b10,1,0, "t1_s2");
    add(0,0,0,0,0, 2'b11,1,0, "t1_s3");
    add(0,0,0,0,0, 2'b00,0,1, "t1_done");
    add(0,0,0,0,0, 2'b00,0,0, "t1_idle");
    // two frames, gap 2
    add(0,1,0,1,2, 2'b01,1,0, "t2_a1");
    add(0,0,0,0,0, 2'b10,1,0, "t2_a2");
    add(0,0,0,0,0, 2'b11,1,0, "t2_a3");
    add(0,0,0,0,0, 2'b00,1,0, "t2_gap1");
    add(0,0,0,0,0, 2'b00,1,0, "t2_gap2");
    add(0,0,0,0,0, 2'b01,1,0, "t2_b1");
    add(0,0,0,0,0, 2'b10,1,0, "t2_b2");
    add(0,0,0,0,0, 2'b11,1,0, "t2_b3");
    add(0,0,0,0,0, 2'b00,0,1, "t2_done");
    add(0,0,0,0,0, 2'b00,0,0, "t2_idle");
    // three frames back to back
    add(0,1,0,2,0, 2'b01,1,0, "t3_a1");
    add(0,0,0,0,0, 2'b10,1,0, "t3_a2");
    add(0,0,0,0,0, 2'b11,1,0, "t3_a3");
    add(0,0,0,0,0, 2'b01,1,0, "t3_b1");
    add(0,0,0,0,0, 2'b10,1,0, "t3_b2");
    add(0,0,0,0,0, 2'b11,1,0, "t3_b3");
    add(0,0,0,0,0, 2'b01,1,0, "t3_c1");
    add(0,0,0,0,0, 2'b10,1,0, "t3_c2");
    add(0,0,0,0,0, 2'b11,1,0, "t3_c3");
    add(0,0,0,0,0, 2'b00,0,1, "t3_done");
    add(0,0,0,0,0, 2'b00,0,0, "t3_idle");
    // mid-flight start and config changes ignored (rc=1, gap=1)
    add(0,1,0,1,1, 2'b01,1,0, "t4_a1");
    add(0,1,0,3,0, 2'b10,1,0, "t4_a2");
    add(0,1,0,0,3, 2'b11,1,0, "t4_a3");
    add(0,0,0,0,3, 2'b00,1,0, "t4_gap");
    add(0,0,0,0,0, 2'b01,1,0, "t4_b1");
    add(0,0,0,0,0, 2'b10,1,0, "t4_b2");
    add(0,0,0,0,0, 2'b11,1,0, "t4_b3");
    add(0,0,0,0,0, 2'b00,0,1, "t4_done");
    add(0,0,0,0,0, 2'b00,0,0, "t4_idle");
    // abort in SYM2, then restart; start in DONE ignored; abort+start in IDLE
    add(0,1,0,3,0, 2'b01,1,0, "t5_s1");
    add(0,0,0,0,0, 2'b10,1,0, "t5_s2");
    add(0,0,1,0,0, 2'b00,0,0, "t5_abort");
    add(0,0,0,0,0, 2'b00,0,0, "t5_no_done");
    add(0,1,1,0,0, 2'b01,1,0, "t5_restart");
    add(0,0,0,0,0, 2'b10,1,0, "t5_r2");
    add(0,0,0,0,0, 2'b11,1,0, "t5_r3");
    add(0,0,0,0,0, 2'b00,0,1, "t5_done");
    add(0,1,0,0,0, 2'b00,0,0, "t5_start_in_done");
    add(0,1,0,0,0, 2'b01,1,0, "t5_next_accept");
    add(0,0,0,0,0, 2'b10,1,0, "t5_n2");
    add(0,0,0,0,0, 2'b11,1,0, "t5_n3");
    add(0,0,0,0,0, 2'b00,0,1, "t5_ndone");
    add(0,0,0,0,0, 2'b00,0,0, "t5_nidle");
    // reset during GAP with start held high
    add(0,1,0,1,3, 2'b01,1,0, "t6_s1");
    add(0,0,0,0,0, 2'b10,1,0, "t6_s2");
    add(0,0,0,0,0, 2'b11,1,0, "t6_s3");
    add(0,0,0,0,0, 2'b00,1,0, "t6_gap");
    add(1,1,0,0,0, 2'b00,0,0, "t6_reset");
    add(1,1,0,0,0, 2'b00,0,0, "t6_reset_hold");
    add(0,1,0,0,0, 2'b01,1,0, "t6_after");
    add(0,0,0,0,0, 2'b10,1,0, "t6_a2");
    add(0,0,0,0,0, 2'b11,1,0, "t6_a3");
    add(0,0,0,0,0, 2'b00,0,1, "t6_done");
    add(0,0,0,0,0, 2'b00,0,0, "t6_idle");

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; start = vecs[i].st; abort = vecs[i].ab;
      repeat_cnt = vecs[i].rc; gap = vecs[i].g;
      tick();
      total++;
      if ({num, busy, done} == {vecs[i].e_num, vecs[i].e_busy, vecs[i].e_done})
        passed++;
      else
        $display("FAIL %s: got num=%b busy=%b done=%b, expected num=%b busy=%b done=%b",
                 vecs[i].name, num, busy, done,
                 vecs[i].e_num, vecs[i].e_busy, vecs[i].e_done);
    end

    // boundaries: 16 frames, max gap -> 48 + 45 busy cycles
    long_run(4'd15, 2'd3, 93, "max_rc_max_gap");
    long_run(4'd15, 2'd0, 48, "max_rc_no_gap");
    long_run(4'd3,  2'd1, 15, "rc3_gap1");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
